// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU_TOP command issuer and its bench.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package alu_pkg;

  // Issuer FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // ALU_FUNC[3:2] selects which ALU unit handles the operation.
  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  // ALU_TOP function codes.
  localparam logic [3:0] FUNC_ADD     = 4'd0;
  localparam logic [3:0] FUNC_SUB     = 4'd1;
  localparam logic [3:0] FUNC_MUL     = 4'd2;
  localparam logic [3:0] FUNC_DIV     = 4'd3;
  localparam logic [3:0] FUNC_AND     = 4'd4;
  localparam logic [3:0] FUNC_OR      = 4'd5;
  localparam logic [3:0] FUNC_NAND    = 4'd6;
  localparam logic [3:0] FUNC_NOR     = 4'd7;
  localparam logic [3:0] FUNC_CMP_NOP = 4'd8;
  localparam logic [3:0] FUNC_CMP_EQ  = 4'd9;
  localparam logic [3:0] FUNC_CMP_GT  = 4'd10;
  localparam logic [3:0] FUNC_CMP_LT  = 4'd11;
  localparam logic [3:0] FUNC_SHR_A   = 4'd12;
  localparam logic [3:0] FUNC_SHL_A   = 4'd13;
  localparam logic [3:0] FUNC_SHR_B   = 4'd14;
  localparam logic [3:0] FUNC_SHL_B   = 4'd15;

  // Unit addressed by a function code.
  function automatic logic [1:0] func_unit(input logic [3:0] func);
    return func[3:2];
  endfunction

endpackage

// File: rtl/alu_result_sel.sv
// alu_result_sel: picks the result, valid flag and carry of the ALU unit addressed by unit.
// Latency: combinational.
// Backpressure: none; pure selection.
module alu_result_sel
  import alu_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic [1:0]       unit,
  input  logic [Width-1:0] arith_out,
  input  logic [Width-1:0] logic_out,
  input  logic [Width-1:0] cmp_out,
  input  logic [Width-1:0] shift_out,
  input  logic             carry_in,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  output logic [Width-1:0] sel_result,
  output logic             sel_flag,
  output logic             sel_carry
);

  // Route only the addressed unit; carry is meaningful for the arithmetic unit alone.
  always_comb begin
    sel_result = '0;
    sel_flag   = 1'b0;
    sel_carry  = 1'b0;
    case (unit)
      UNIT_ARITH: begin
        sel_result = arith_out;
        sel_flag   = arith_flag;
        sel_carry  = carry_in;
      end
      UNIT_LOGIC: begin
        sel_result = logic_out;
        sel_flag   = logic_flag;
      end
      UNIT_CMP: begin
        sel_result = cmp_out;
        sel_flag   = cmp_flag;
      end
      UNIT_SHIFT: begin
        sel_result = shift_out;
        sel_flag   = shift_flag;
      end
      default: begin
        sel_result = '0;
        sel_flag   = 1'b0;
        sel_carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: issues one (A, B, ALU_FUNC) op to ALU_TOP, waits for the addressed unit's flag, returns its result.
// Latency: accept -> rsp_valid 2 cycles (ALU samples at +1, capture at +2); timeout after TIMEOUT WAIT cycles; 4-cycle min op interval.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready. ALU_ISSUER_STATS_EN adds op_count/timeout_count.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int Width   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [Width-1:0] cmd_a,
  input  logic [Width-1:0] cmd_b,
  input  logic [3:0]       cmd_func,
  output logic [Width-1:0] ALU_A,
  output logic [Width-1:0] ALU_B,
  output logic [3:0]       ALU_FUNC,
  input  logic [Width-1:0] Arith_OUT,
  input  logic [Width-1:0] Logic_OUT,
  input  logic [Width-1:0] CMP_OUT,
  input  logic [Width-1:0] SHIFT_OUT,
  input  logic             Carry_OUT,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             SHIFT_Flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [Width-1:0] rsp_data,
  output logic             rsp_carry,
  output logic [3:0]       rsp_func,
`ifdef ALU_ISSUER_STATS_EN
  output logic [15:0]      op_count,
  output logic [7:0]       timeout_count,
`endif
  output logic             rsp_timeout
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       func_q;
  logic [CntW-1:0]  wait_cnt;

  logic             accept;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cap_ok;
  logic             cap_to;
  logic             rsp_done;

  logic [Width-1:0] sel_result;
  logic             sel_flag;
  logic             sel_carry;

  // Held low through reset so no command is taken while the block is being cleared.
  assign cmd_ready = (state == ST_IDLE) && RST;
  assign rsp_valid = (state == ST_RESP);

  alu_result_sel #(
    .Width (Width)
  ) u_sel (
    .unit       (func_unit(func_q)),
    .arith_out  (Arith_OUT),
    .logic_out  (Logic_OUT),
    .cmp_out    (CMP_OUT),
    .shift_out  (SHIFT_OUT),
    .carry_in   (Carry_OUT),
    .arith_flag (Arith_Flag),
    .logic_flag (Logic_Flag),
    .cmp_flag   (CMP_Flag),
    .shift_flag (SHIFT_Flag),
    .sel_result (sel_result),
    .sel_flag   (sel_flag),
    .sel_carry  (sel_carry)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-state datapath strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cap_ok    = 1'b0;
    cap_to    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // ALU samples the held inputs on this edge.
        cnt_clr   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (sel_flag) begin
          cap_ok    = 1'b1;
          state_nxt = ST_RESP;
        end else if (wait_cnt == CntLast) begin
          cap_to    = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the accepted command; ALU inputs keep the last issued values while idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUNC <= '0;
      func_q   <= '0;
    end else if (accept) begin
      ALU_A    <= cmd_a;
      ALU_B    <= cmd_b;
      ALU_FUNC <= cmd_func;
      func_q   <= cmd_func;
    end
  end

  // WAIT-cycle counter, restarted as each op is issued.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt <= '0;
    end else if (cnt_clr) begin
      wait_cnt <= '0;
    end else if (cnt_inc) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Response capture; registers hold until the next capture so RESP stays stable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_data    <= '0;
      rsp_carry   <= 1'b0;
      rsp_func    <= '0;
      rsp_timeout <= 1'b0;
    end else if (cap_ok) begin
      rsp_data    <= sel_result;
      rsp_carry   <= sel_carry;
      rsp_func    <= func_q;
      rsp_timeout <= 1'b0;
    end else if (cap_to) begin
      rsp_data    <= '0;
      rsp_carry   <= 1'b0;
      rsp_func    <= func_q;
      rsp_timeout <= 1'b1;
    end
  end

`ifdef ALU_ISSUER_STATS_EN
  // Handshake statistics: op_count wraps, timeout_count saturates.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op_count      <= '0;
      timeout_count <= '0;
    end else if (rsp_done) begin
      op_count <= op_count + 16'd1;
      if (rsp_timeout && (timeout_count != 8'hFF)) begin
        timeout_count <= timeout_count + 8'd1;
      end
    end
  end
`else
  // Statistics are not built; rsp_done only drives the FSM.
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
`timescale 1ns/1ps
// Bench for alu_cmd_issuer: behavioural ALU_TOP model plus a response scoreboard.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int TO = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         carry;
    logic [3:0]   func;
    logic         to;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [3:0]   cmd_func = '0;
  logic [W-1:0] ALU_A, ALU_B;
  logic [3:0]   ALU_FUNC;
  logic [W-1:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, SHIFT_OUT = '0;
  logic         Carry_OUT = 1'b0;
  logic         Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, SHIFT_Flag = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_data;
  logic         rsp_carry;
  logic [3:0]   rsp_func;
  logic         rsp_timeout;
`ifdef ALU_ISSUER_STATS_EN
  logic [15:0]  op_count;
  logic [7:0]   timeout_count;
`endif

  logic shift_dead = 1'b0;   // shift unit never raises its flag
  logic noise      = 1'b0;   // non-addressed units raise their flags too
  exp_t sb[$];
  exp_t got_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  time  t_acc;

  always #5 CLK = ~CLK;

  alu_cmd_issuer #(.Width(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .Carry_OUT(Carry_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_func(rsp_func),
`ifdef ALU_ISSUER_STATS_EN
    .op_count(op_count), .timeout_count(timeout_count),
`endif
    .rsp_timeout(rsp_timeout)
  );

  // ALU_TOP behaviour: bit W is the carry (arith only).
  function automatic logic [W:0] unit_calc(input logic [1:0] u, input logic [1:0] op,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]     r;
    logic [2*W-1:0] p;
    r = '0;
    p = a * b;
    case (u)
      UNIT_ARITH: case (op)
        2'd0: r = {1'b0, a} + {1'b0, b};
        2'd1: r = {1'b0, a} - {1'b0, b};
        2'd2: r = p[W:0];
        default: r = (b == '0) ? '0 : {1'b0, a / b};
      endcase
      UNIT_LOGIC: case (op)
        2'd0: r = {1'b0, a & b};
        2'd1: r = {1'b0, a | b};
        2'd2: r = {1'b0, ~(a & b)};
        default: r = {1'b0, ~(a | b)};
      endcase
      UNIT_CMP: case (op)
        2'd0: r = '0;
        2'd1: r = (a == b) ? 17'd1 : 17'd0;
        2'd2: r = (a > b)  ? 17'd2 : 17'd0;
        default: r = (a < b) ? 17'd3 : 17'd0;
      endcase
      default: case (op)
        2'd0: r = {1'b0, a >> 1};
        2'd1: r = {1'b0, a << 1};
        2'd2: r = {1'b0, b >> 1};
        default: r = {1'b0, b << 1};
      endcase
    endcase
    return r;
  endfunction

  function automatic exp_t make_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    exp_t       e;
    logic [W:0] r;
    r      = unit_calc(f[3:2], f[1:0], a, b);
    e.func = f;
    if (shift_dead && f[3:2] == UNIT_SHIFT) begin
      e.data = '0; e.carry = 1'b0; e.to = 1'b1;
    end else begin
      e.data = r[W-1:0]; e.carry = (f[3:2] == UNIT_ARITH) ? r[W] : 1'b0; e.to = 1'b0;
    end
    return e;
  endfunction

  // Every unit computes on the current ALU inputs; outputs and flags are registered.
  logic [W:0] ar, lr, cr, sr;
  always_comb ar = unit_calc(UNIT_ARITH, ALU_FUNC[1:0], ALU_A, ALU_B);
  always_comb lr = unit_calc(UNIT_LOGIC, ALU_FUNC[1:0], ALU_A, ALU_B);
  always_comb cr = unit_calc(UNIT_CMP,   ALU_FUNC[1:0], ALU_A, ALU_B);
  always_comb sr = unit_calc(UNIT_SHIFT, ALU_FUNC[1:0], ALU_A, ALU_B);

  always @(posedge CLK) begin
    Arith_OUT  <= ar[W-1:0];
    Carry_OUT  <= ar[W];
    Logic_OUT  <= lr[W-1:0];
    CMP_OUT    <= cr[W-1:0];
    SHIFT_OUT  <= sr[W-1:0];
    Arith_Flag <= (ALU_FUNC[3:2] == UNIT_ARITH) || noise;
    Logic_Flag <= (ALU_FUNC[3:2] == UNIT_LOGIC) || noise;
    CMP_Flag   <= (ALU_FUNC[3:2] == UNIT_CMP)   || noise;
    SHIFT_Flag <= ((ALU_FUNC[3:2] == UNIT_SHIFT) || noise) && !shift_dead;
  end

  // Response monitor: record every completed handshake.
  always @(posedge CLK) begin
    if (rsp_valid && rsp_ready) got_q.push_back(exp_t'({rsp_data, rsp_carry, rsp_func, rsp_timeout}));
  end

  // Drive one command; the expected response is queued when it is accepted.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f, input bit keep);
    int n;
    @(negedge CLK);
    cmd_a = a; cmd_b = b; cmd_func = f; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 30) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL issue_accept func=%0d: cmd_ready=%b, required 1 within 30 cycles", f, cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(posedge CLK);
      t_acc = $time;
      sb.push_back(make_exp(a, b, f));
      @(negedge CLK);
      if (!keep) cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge CLK);
      lat++;
      if (rsp_valid) break;
    end
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 60 && got_q.size() < n; i++) @(negedge CLK);
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: cmd_ready=%b, required 0", cmd_ready); end
    vectors++;
    if ({ALU_A, ALU_B, ALU_FUNC, rsp_valid, rsp_data, rsp_carry, rsp_func, rsp_timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: A=%h B=%h F=%h rv=%b rd=%h rc=%b rf=%h rt=%b, required all 0",
               ALU_A, ALU_B, ALU_FUNC, rsp_valid, rsp_data, rsp_carry, rsp_func, rsp_timeout);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready: cmd_ready=%b, required 1", cmd_ready); end
  endtask

  task automatic test_add();
    int   lat;
    exp_t e, g;
    issue(16'd10, 16'd20, FUNC_ADD, 1'b0);
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_early_valid: rsp_valid=%b, required 0", rsp_valid); end
    wait_valid(lat);
    vectors++;
    if (lat != 2) begin miscompares++; $display("FAIL add_latency: %0d cycles, required 2", lat); end
    wait_got(1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (got_q.size() == 0) begin miscompares++; $display("FAIL add_rsp: no response, required data=%0d", e.data); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL add_rsp: got d=%0d c=%b f=%0d t=%b, required d=%0d c=%b f=%0d t=%b", g.data, g.carry, g.func, g.to, e.data, e.carry, e.func, e.to); end
      end
    end
  endtask

  task automatic test_back_to_back();
    time  t1;
    exp_t e, g;
    rsp_ready = 1'b1;
    issue(16'd20, 16'd10, FUNC_NOR, 1'b1);
    t1 = t_acc;
    issue(16'd20, 16'd10, FUNC_NAND, 1'b0);
    vectors++;
    if (t_acc - t1 != 40) begin miscompares++; $display("FAIL b2b_interval: %0t, required 40 (4 cycles)", t_acc - t1); end
    wait_got(2);
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (got_q.size() == 0) begin miscompares++; $display("FAIL b2b_rsp: no response, required data=%0d", e.data); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL b2b_rsp: got d=%0d c=%b f=%0d t=%b, required d=%0d c=%b f=%0d t=%b", g.data, g.carry, g.func, g.to, e.data, e.carry, e.func, e.to); end
      end
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e, g;
    rsp_ready = 1'b0;
    issue(16'd20, 16'd10, FUNC_SHR_A, 1'b0);
    wait_valid(lat);
    e = sb[0];
    cmd_a = 16'd7; cmd_b = 16'd7; cmd_func = FUNC_ADD; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, rsp_data, rsp_carry, rsp_func, rsp_timeout} !== {1'b1, e.data, e.carry, e.func, e.to}) begin
        miscompares++;
        $display("FAIL stall_hold cyc%0d: v=%b d=%0d f=%0d, required v=1 d=%0d f=%0d", i, rsp_valid, rsp_data, rsp_func, e.data, e.func);
      end
      vectors++;
      if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready cyc%0d: cmd_ready=%b, required 0", i, cmd_ready); end
      @(negedge CLK);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLK);
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release: rsp_valid=%b, required 0", rsp_valid); end
    wait_got(1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (got_q.size() == 0) begin miscompares++; $display("FAIL stall_rsp: no response, required data=%0d", e.data); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL stall_rsp: got d=%0d c=%b f=%0d t=%b, required d=%0d c=%b f=%0d t=%b", g.data, g.carry, g.func, g.to, e.data, e.carry, e.func, e.to); end
      end
    end
  endtask

  task automatic test_timeout();
    int   lat;
    exp_t e, g;
    shift_dead = 1'b1;
    noise      = 1'b1;
    issue(16'h1234, 16'd1, FUNC_SHL_A, 1'b0);
    wait_valid(lat);
    vectors++;
    if (lat != 1 + TO) begin miscompares++; $display("FAIL timeout_latency: %0d cycles, required %0d", lat, 1 + TO); end
    wait_got(1);
    shift_dead = 1'b0;
    noise      = 1'b0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (got_q.size() == 0) begin miscompares++; $display("FAIL timeout_rsp: no response, required timeout=1"); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL timeout_rsp: got d=%0d c=%b f=%0d t=%b, required d=%0d c=%b f=%0d t=%b", g.data, g.carry, g.func, g.to, e.data, e.carry, e.func, e.to); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e, g;
    shift_dead = 1'b1;
    issue(16'd20, 16'd10, FUNC_SHL_A, 1'b0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    vectors++;
    if ({ALU_A, ALU_B, ALU_FUNC, rsp_valid, rsp_data, rsp_carry, rsp_func, rsp_timeout} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: A=%h B=%h F=%h rv=%b rd=%h, required all 0", ALU_A, ALU_B, ALU_FUNC, rsp_valid, rsp_data);
    end
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ready: cmd_ready=%b, required 0", cmd_ready); end
    sb.delete();
    got_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    shift_dead = 1'b0;
    issue(16'd20, 16'd10, FUNC_CMP_GT, 1'b0);
    wait_got(1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (got_q.size() == 0) begin miscompares++; $display("FAIL postreset_rsp: no response, required data=%0d", e.data); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL postreset_rsp: got d=%0d c=%b f=%0d t=%b, required d=%0d c=%b f=%0d t=%b", g.data, g.carry, g.func, g.to, e.data, e.carry, e.func, e.to); end
      end
    end
  endtask

  task automatic test_stats();
    exp_t e, g;
    issue(16'hFFFF, 16'd2, FUNC_ADD, 1'b0);
    issue(16'hFFFF, 16'hFFFF, FUNC_AND, 1'b0);
    shift_dead = 1'b1;
    noise      = 1'b1;
    issue(16'h0F0F, 16'd3, FUNC_SHL_B, 1'b0);
    wait_got(3);
    shift_dead = 1'b0;
    noise      = 1'b0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (got_q.size() == 0) begin miscompares++; $display("FAIL stats_rsp: no response, required data=%0d", e.data); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL stats_rsp: got d=%0d c=%b f=%0d t=%b, required d=%0d c=%b f=%0d t=%b", g.data, g.carry, g.func, g.to, e.data, e.carry, e.func, e.to); end
      end
    end
    @(negedge CLK);
`ifdef ALU_ISSUER_STATS_EN
    vectors++;
    if (op_count !== 16'd4) begin miscompares++; $display("FAIL op_count: %0d, required 4", op_count); end
    vectors++;
    if (timeout_count !== 8'd1) begin miscompares++; $display("FAIL timeout_count: %0d, required 1", timeout_count); end
`endif
    vectors++;
    if (got_q.size() != 0) begin miscompares++; $display("FAIL spurious_rsp: %0d extra responses, required 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator for the ALU_TOP datapath. It accepts one operation at a time (A, B, ALU_FUNC) over a valid/ready command port and drives the ALU inputs. It then waits for the flag of the ALU unit that was addressed, captures that unit's result, and returns it over a valid/ready response port. It sits between a command source (test sequencer or future control unit) and ALU_TOP, so no upstream logic has to decode the four per-unit output/flag groups.

Parameters:
Width, 16, operand and result width; must match ALU_TOP Width.
TIMEOUT, 4, maximum cycles spent in WAIT before a timeout response is returned (minimum 1).

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  reset, asynchronous, active-low.
cmd_valid  input  1  command present.
cmd_ready  output  1  issuer can accept a command.
cmd_a  input  Width  operand A.
cmd_b  input  Width  operand B.
cmd_func  input  4  ALU function code; [3:2] selects unit: 00 arith, 01 logic, 10 cmp, 11 shift.
ALU_A  output  Width  to ALU_TOP A.
ALU_B  output  Width  to ALU_TOP B.
ALU_FUNC  output  4  to ALU_TOP ALU_FUNC.
Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT  input  Width each  ALU unit results.
Carry_OUT  input  1  ALU arithmetic carry.
Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag  input  1 each  ALU unit result-valid flags.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_data  output  Width  captured result.
rsp_carry  output  1  captured Carry_OUT; 0 for non-arith units.
rsp_func  output  4  function code of this response.
rsp_timeout  output  1  selected flag never rose; rsp_data forced to 0.

Behaviour:
- Reset (RST low, asynchronous): state IDLE; cmd_ready=0 while RST low; ALU_A, ALU_B, ALU_FUNC, rsp_* all 0; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP. Only one operation is outstanding at a time.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready at an edge: latch cmd_a/cmd_b/cmd_func into ALU_A/ALU_B/ALU_FUNC and an internal func register; go to ISSUE.
- ISSUE:
  - cmd_ready=0; ALU inputs are held.
  - The ALU samples them at the next edge; go to WAIT; clear the timeout counter.
- WAIT: monitor only the flag selected by func[3:2]; flags of other units are ignored.
  - Flag=1: capture the selected *_OUT into rsp_data, Carry_OUT into rsp_carry if arith (else 0), and func into rsp_func; rsp_timeout=0; go to RESP.
  - Counter reaches TIMEOUT-1 with flag still 0: rsp_data=0, rsp_carry=0, rsp_timeout=1; go to RESP.
  - Otherwise increment the counter.
- RESP:
  - rsp_valid=1; rsp_* stable until handshake.
  - On rsp_ready: rsp_valid drops at the next edge; go to IDLE.
  - rsp_ready held high means no stall.
- Latency: accept at edge E0, ALU samples at E1, result captured at E2, so rsp_valid is high after E2 (2 cycles). The minimum command-to-command interval is 4 cycles.
- ALU inputs hold the last issued values between operations (no re-drive in IDLE).
- Division by zero, shift amount and other operand semantics are passed through unchecked.
- cmd_valid outside IDLE is ignored (cmd_ready=0) and must be held by the source.
- Reset mid-operation: the in-flight command and any pending response are discarded; the block restarts in IDLE.
- rsp_ready asserted while rsp_valid=0 has no effect.

Optional Feature:
ALU_ISSUER_STATS_EN:
- Defined: adds outputs op_count (16 bits, increments on each response handshake, wraps at 65535→0) and timeout_count (8 bits, increments on timeout-response handshake, saturates at 255). Both counters are cleared by RST.
- Not defined: neither port nor the counters exist.

Decomposition:
- Shared package alu_pkg:
  - FSM state encoding (2 bits).
  - Unit-select constants UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11.
  - The 16 ALU_FUNC code constants, shared with ALU_TOP and its bench.
- Sub-module alu_result_sel (combinational): selects result, flag and carry by unit select.

Test Plan:
- Add: cmd 10,20,func 0 → rsp_data=30, rsp_carry=0, rsp_timeout=0; rsp_valid 2 cycles after accept.
- Logic back-to-back with rsp_ready=1: NOR 20,10 (func 7) → 65505; then NAND (func 6) → 65535; each accept occurs only in IDLE, 4 cycles apart.
- Backpressure: shift 20,10 func 12 → rsp_data=10; hold rsp_ready=0 for 5 cycles → rsp_* stable and cmd_ready=0 throughout.
- Timeout: tie SHIFT_Flag=0, issue func 13 → after TIMEOUT=4 WAIT cycles, rsp_timeout=1 and rsp_data=0.
- Reset mid-WAIT: pull RST low during WAIT → all outputs 0 immediately; after release, a CMP func 10 cmd 20,10 returns 2.
- ALU_ISSUER_STATS_EN: 3 normal ops plus 1 timeout → op_count=4, timeout_count=1.
